vrf_operand_fetch: RTL
======================

# vrf_operand_fetch

Sequencer that reads two vector operands out of the vector register file element by element and streams them to the vector ALU. It accepts one command holding two source register indices and a vector length. It drives both read ports of the register file, addressing {register, element}, and presents element pairs on a valid/ready output stream, one pair per cycle when the consumer does not stall. It sits between the vector instruction decode/issue logic and the vector execution lanes.

## Interface
- ADDR_WIDTH, 5, width of the register index and of the element index
- DATA_WIDTH, 32, element width
- NUM_REG, 6, number of implemented vector registers
- NUM_ELE, 32, maximum elements per vector
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_vs1  in  ADDR_WIDTH  first source register
- cmd_vs2  in  ADDR_WIDTH  second source register
- cmd_vl  in  ADDR_WIDTH+1  element count, 0..NUM_ELE
- rf_rAddr1_1 / rf_rAddr2_1  out  ADDR_WIDTH each  read port 1 register / element
- rf_rData1  in  DATA_WIDTH  read port 1 data, combinational from the address
- rf_rAddr1_2 / rf_rAddr2_2  out  ADDR_WIDTH each  read port 2 register / element
- rf_rData2  in  DATA_WIDTH  read port 2 data
- out_valid  out  1  element pair valid
- out_ready  in  1  consumer accepts the pair
- out_data1 / out_data2  out  DATA_WIDTH each  element of vs1 / vs2
- out_idx  out  ADDR_WIDTH  element index
- out_last  out  1  final element of the command
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when the command completes
- err  out  1  one-cycle pulse when an illegal command is rejected

## Operation
- States: IDLE, FETCH, DRAIN. cmd_ready = (state == IDLE).
- IDLE, on handshake:
  - An illegal command (vs1 ≥ NUM_REG, vs2 ≥ NUM_REG, or vl > NUM_ELE) is consumed. err pulses the next cycle. The state stays IDLE.
  - A legal command with vl == 0 is consumed. done pulses the next cycle. No output is produced. The state stays IDLE.
  - Any other command latches vs1, vs2 and vl, sets idx = 0, and moves to FETCH.
- Read addresses:
  - rf_rAddr1_1 = vs1_q, rf_rAddr1_2 = vs2_q, and both element addresses = idx_q.
  - All read addresses are 0 in IDLE.
  - They are registered values, so they stay stable while the output is stalled.
- FETCH:
  - load = !out_valid || out_ready.
  - On load: out_data1/2 ← rf_rData1/2, out_idx ← idx, out_last ← (idx == vl−1), out_valid ← 1, idx ← idx+1.
  - When the loaded element is the last one, the state moves to DRAIN.
- DRAIN: when out_valid && out_ready, out_valid ← 0, done pulses the next cycle, and the state moves to IDLE.
- In FETCH, when out_valid && out_ready && !load, out_valid ← 0. This case cannot occur, because acceptance always causes a load; the rule is kept for safety.
- Data is sampled at the load edge. A register-file write to the same element in an earlier cycle is visible. Hazard ordering is the issuer's responsibility.
- The element counter width is ADDR_WIDTH+1, so vl == NUM_ELE never wraps.

## Timing
- Reset values: state IDLE, cmd_ready 1, out_valid 0, out_data1/2 0, out_idx 0, out_last 0, all rf addresses 0, busy 0, done 0, err 0.
- A reset asserted mid-command aborts it. out_valid is 0 in the cycle after the reset edge, and no done pulse is produced.
- Command handshake in cycle 0 → element 0 valid in cycle 2. With out_ready held high, element i is valid in cycle 2+i and out_last in cycle vl+1. done pulses and cmd_ready returns in cycle vl+2.
- The output holds its data while out_valid && !out_ready (AXI-style). There is no bubble on back-to-back accepts.

## Structure
- Shared package vrf_pkg holds the state enum and the default values of ADDR_WIDTH, DATA_WIDTH, NUM_REG and NUM_ELE, shared with the register file and issue logic.
- One sub-module, vrf_pipe_reg: a parameterised valid/ready output register carrying {data1, data2, idx, last}.
- The FSM and counter stay in the top module.

## Test plan
- Preload v1[i] = i and v2[i] = 0x100+i. Send command vs1=1, vs2=2, vl=4 with out_ready=1 → pairs (0,0x100)…(3,0x103) appear in cycles 2–5, out_last only in cycle 5, done in cycle 6.
- Same command with out_ready toggling 1,0,0,1,… → no pair is lost or duplicated, the data and rf addresses stay stable during stalls, and out_idx is sequential.
- vl=32 (NUM_ELE) → 32 pairs with out_idx 0..31 and no wrap. vl=0 → no out_valid, done pulses one cycle after the handshake.
- vs1=6 with NUM_REG=6, or vl=33 → err pulses once, no output, cmd_ready stays 1.
- Assert reset while element 3 of 8 is stalled → out_valid=0, busy=0 and cmd_ready=1 after the reset edge. A following command streams correctly from element 0.
- Two back-to-back commands → the second handshake is accepted only in the cycle done pulses, and its first pair appears two cycles later.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared vector register file definitions: default geometry and sequencer state codes.
// Used by the operand fetch sequencer, the register file and the issue logic.
// No logic; types and constants only.
package vrf_pkg;

    localparam int VRF_ADDR_WIDTH = 5;
    localparam int VRF_DATA_WIDTH = 32;
    localparam int VRF_NUM_REG    = 6;
    localparam int VRF_NUM_ELE    = 32;

    // Operand fetch sequencer states
    typedef logic [1:0] vrf_state_t;
    localparam vrf_state_t ST_IDLE  = 2'd0;
    localparam vrf_state_t ST_FETCH = 2'd1;
    localparam vrf_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/vrf_pipe_reg.sv
// Single-entry valid/ready output register (AXI-style skid-free stage).
// Latency: 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, so data holds while stalled and
// back-to-back accepts run without a bubble.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module vrf_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_valid && out_ready) begin
            // Accepted with nothing new behind it: the stage empties.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vrf_operand_fetch.sv
// Vector operand fetch: reads vs1/vs2 element by element from both RF read ports and
// streams element pairs to the vector ALU. Latency: handshake cycle 0 -> element 0 valid
// in cycle 2, then one pair per cycle. Backpressure: out_ready stalls the output register
// and freezes the read addresses; commands are only accepted in IDLE (cmd_ready).
// Ports: cmd_* command in, rf_* register file read ports, out_* element pair stream,
// busy/done/err status (done/err are one-cycle pulses).
module vrf_operand_fetch
    import vrf_pkg::*;
#(
    parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
    parameter int DATA_WIDTH = VRF_DATA_WIDTH,
    parameter int NUM_REG    = VRF_NUM_REG,
    parameter int NUM_ELE    = VRF_NUM_ELE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_vs1,
    input  logic [ADDR_WIDTH-1:0] cmd_vs2,
    input  logic [ADDR_WIDTH:0]   cmd_vl,
    output logic [ADDR_WIDTH-1:0] rf_rAddr1_1,
    output logic [ADDR_WIDTH-1:0] rf_rAddr2_1,
    input  logic [DATA_WIDTH-1:0] rf_rData1,
    output logic [ADDR_WIDTH-1:0] rf_rAddr1_2,
    output logic [ADDR_WIDTH-1:0] rf_rAddr2_2,
    input  logic [DATA_WIDTH-1:0] rf_rData2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Counter is one bit wider than the element index so vl == NUM_ELE compares cleanly.
    localparam int CW = ADDR_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH + ADDR_WIDTH + 1;

    vrf_state_t            state_q;
    logic [ADDR_WIDTH-1:0] vs1_q;
    logic [ADDR_WIDTH-1:0] vs2_q;
    logic [CW-1:0]         idx_q;
    logic [CW-1:0]         vl_q;
    logic                  done_q;
    logic                  err_q;

    logic                  cmd_fire;
    logic                  cmd_illegal;
    logic                  pipe_in_valid;
    logic                  pipe_in_ready;
    logic                  load;
    logic                  is_last;
    logic                  out_fire;
    logic [PW-1:0]         pipe_in;
    logic [PW-1:0]         pipe_out;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = !cmd_ready;
    assign done        = done_q;
    assign err         = err_q;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cmd_illegal = (cmd_vs1 >= ADDR_WIDTH'(NUM_REG)) ||
                         (cmd_vs2 >= ADDR_WIDTH'(NUM_REG)) ||
                         (cmd_vl > CW'(NUM_ELE));

    // Read addresses come straight from registers, so they are glitch-free and stay
    // put while the output is stalled; all are cleared whenever the sequencer is idle.
    assign rf_rAddr1_1 = vs1_q;
    assign rf_rAddr1_2 = vs2_q;
    assign rf_rAddr2_1 = idx_q[ADDR_WIDTH-1:0];
    assign rf_rAddr2_2 = idx_q[ADDR_WIDTH-1:0];

    assign pipe_in_valid = (state_q == ST_FETCH);
    assign load          = pipe_in_valid && pipe_in_ready;
    assign is_last       = ((idx_q + CW'(1)) == vl_q);
    assign out_fire      = out_valid && out_ready;
    assign pipe_in       = {rf_rData1, rf_rData2, idx_q[ADDR_WIDTH-1:0], is_last};

    vrf_pipe_reg #(.W(PW)) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (pipe_in_valid),
        .in_ready  (pipe_in_ready),
        .in_data   (pipe_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pipe_out)
    );

    assign {out_data1, out_data2, out_idx, out_last} = pipe_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vs1_q   <= '0;
            vs2_q   <= '0;
            idx_q   <= '0;
            vl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_illegal) begin
                            err_q <= 1'b1;
                        end else if (cmd_vl == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            vs1_q   <= cmd_vs1;
                            vs2_q   <= cmd_vs2;
                            vl_q    <= cmd_vl;
                            idx_q   <= '0;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (load) begin
                        // Hold the index on the last element so the addresses do not
                        // run past the vector while the final pair drains.
                        if (is_last) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            idx_q <= idx_q + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        vs1_q   <= '0;
                        vs2_q   <= '0;
                        idx_q   <= '0;
                        vl_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
